// File: rtl/seg7_display_ctrl.sv
// -----------------------------------------------------------------------------
// seg7_display_ctrl
//
// Avalon-MM slave that drives up to eight active-low 7-segment digits.
// Each digit shows either a raw segment byte or a hex-decoded nibble. Digits
// can be individually disabled, and with the optional blink feature they can
// be blanked periodically.
//
// Build option: define SEG7_BLINK_EN to include the blink counter, the phase
// flag, CTRL.BLINK_EN, CTRL.BLINK_MASK, BLINK_DIV and STATUS. Without it those
// registers read as zero, writes to them are ignored, and only the per-digit
// ENABLE mask can blank a digit.
//
// Register map (word address):
//   0 RAW_LO    byte d[6:0] = raw segments of digit d (d = 0..3)
//   1 RAW_HI    byte d[6:0] = raw segments of digit d+4
//   2 HEX       nibble d    = hex value of digit d
//   3 CTRL      [0] MODE (0 raw, 1 hex), [1] BLINK_EN,
//               [15:8] ENABLE mask, [23:16] BLINK_MASK
//   4 BLINK_DIV [23:0]
//   5 STATUS    [0] blink phase (read-only)
//
// Ports:
//   clk        clock
//   reset_n    asynchronous active-low reset
//   address    Avalon-MM word address
//   chipselect slave select
//   write_n    active-low write strobe
//   writedata  write data
//   readdata   read data, combinational from address (zero wait states)
//   seg_out    registered active-low segments, digit d in [7d+6:7d], g in bit 6
// -----------------------------------------------------------------------------
module seg7_display_ctrl #(
    parameter int          NUM_DIGITS    = 8,
    parameter logic [23:0] BLINK_DIV_RST = 24'd12_500_000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [2:0]              address,
    input  logic                    chipselect,
    input  logic                    write_n,
    input  logic [31:0]             writedata,
    output logic [31:0]             readdata,
    output logic [7*NUM_DIGITS-1:0] seg_out
);

    // One bit per digit that physically exists; register bits of absent
    // digits are forced to zero so they neither store nor read back.
    localparam logic [7:0] DIGIT_MASK = 8'((9'd1 << NUM_DIGITS) - 9'd1);

    function automatic logic [6:0] hex_decode(input logic [3:0] value);
        logic [6:0] pattern;
        case (value)
            4'h0: pattern = 7'h40;
            4'h1: pattern = 7'h79;
            4'h2: pattern = 7'h24;
            4'h3: pattern = 7'h30;
            4'h4: pattern = 7'h19;
            4'h5: pattern = 7'h12;
            4'h6: pattern = 7'h02;
            4'h7: pattern = 7'h78;
            4'h8: pattern = 7'h00;
            4'h9: pattern = 7'h10;
            4'hA: pattern = 7'h08;
            4'hB: pattern = 7'h03;
            4'hC: pattern = 7'h46;
            4'hD: pattern = 7'h21;
            4'hE: pattern = 7'h06;
            default: pattern = 7'h0E;
        endcase
        return pattern;
    endfunction

    logic wr;
    logic wr_hex;
    logic wr_ctrl;
    logic wr_div;

    assign wr      = chipselect & ~write_n;
    assign wr_hex  = wr && (address == 3'd2);
    assign wr_ctrl = wr && (address == 3'd3);
    assign wr_div  = wr && (address == 3'd4);

    // ------------------------------------------------------------------
    // CTRL: MODE and ENABLE (always present)
    // ------------------------------------------------------------------
    logic       mode_reg;
    logic [7:0] enable_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_reg   <= 1'b0;
            enable_reg <= DIGIT_MASK;
        end else if (wr_ctrl) begin
            mode_reg   <= writedata[0];
            enable_reg <= writedata[15:8] & DIGIT_MASK;
        end
    end

    // ------------------------------------------------------------------
    // Blink feature
    // ------------------------------------------------------------------
    logic        blink_en;
    logic [7:0]  blink_mask;
    logic [23:0] blink_div;
    logic        phase;

`ifdef SEG7_BLINK_EN
    logic        blink_en_reg;
    logic [7:0]  blink_mask_reg;
    logic [23:0] blink_div_reg;
    logic [23:0] blink_cnt_reg;
    logic        phase_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_en_reg   <= 1'b0;
            blink_mask_reg <= 8'h00;
        end else if (wr_ctrl) begin
            blink_en_reg   <= writedata[1];
            blink_mask_reg <= writedata[23:16] & DIGIT_MASK;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_div_reg <= BLINK_DIV_RST;
        end else if (wr_div) begin
            blink_div_reg <= writedata[23:0];
        end
    end

    // The counter reacts to the CTRL value held before this edge, so a CTRL
    // write coinciding with a wrap still toggles phase. The >= compare lets a
    // newly written smaller divider wrap immediately instead of overshooting.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt_reg <= 24'd0;
            phase_reg     <= 1'b0;
        end else if (!blink_en_reg) begin
            blink_cnt_reg <= 24'd0;
            phase_reg     <= 1'b0;
        end else if (wr_div) begin
            blink_cnt_reg <= 24'd0;
        end else if (blink_cnt_reg >= blink_div_reg) begin
            blink_cnt_reg <= 24'd0;
            phase_reg     <= ~phase_reg;
        end else begin
            blink_cnt_reg <= blink_cnt_reg + 24'd1;
        end
    end

    assign blink_en   = blink_en_reg;
    assign blink_mask = blink_mask_reg;
    assign blink_div  = blink_div_reg;
    assign phase      = phase_reg;
`else
    assign blink_en   = 1'b0;
    assign blink_mask = 8'h00;
    assign blink_div  = 24'd0;
    assign phase      = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Per-digit storage and output pipeline
    // ------------------------------------------------------------------
    logic [55:0] raw_all;
    logic [31:0] hex_all;

    for (genvar gi = 0; gi < 8; gi++) begin : g_digit
        if (gi < NUM_DIGITS) begin : g_on
            localparam logic [2:0] RAW_ADDR = (gi < 4) ? 3'd0 : 3'd1;

            logic       raw_we;
            logic [6:0] raw_reg;
            logic [3:0] hex_reg;
            logic [6:0] pattern_next;
            logic [6:0] seg_reg;

            assign raw_we = wr && (address == RAW_ADDR);

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    raw_reg <= 7'h40;
                    hex_reg <= 4'h0;
                end else begin
                    if (raw_we) begin
                        raw_reg <= writedata[(gi % 4) * 8 +: 7];
                    end
                    if (wr_hex) begin
                        hex_reg <= writedata[gi * 4 +: 4];
                    end
                end
            end

            always_comb begin
                pattern_next = mode_reg ? hex_decode(hex_reg) : raw_reg;
                if (!enable_reg[gi] || (blink_en && blink_mask[gi] && phase)) begin
                    pattern_next = 7'h7F;
                end
            end

            // Built from the registers as they stand, so a register write
            // shows on the pins one edge later.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    seg_reg <= 7'h40;
                end else begin
                    seg_reg <= pattern_next;
                end
            end

            assign seg_out[gi * 7 +: 7] = seg_reg;
            assign raw_all[gi * 7 +: 7] = raw_reg;
            assign hex_all[gi * 4 +: 4] = hex_reg;
        end else begin : g_off
            assign raw_all[gi * 7 +: 7] = 7'h00;
            assign hex_all[gi * 4 +: 4] = 4'h0;
        end
    end

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    always_comb begin
        readdata = 32'd0;
        case (address)
            3'd0: readdata = {1'b0, raw_all[27:21], 1'b0, raw_all[20:14],
                              1'b0, raw_all[13:7],  1'b0, raw_all[6:0]};
            3'd1: readdata = {1'b0, raw_all[55:49], 1'b0, raw_all[48:42],
                              1'b0, raw_all[41:35], 1'b0, raw_all[34:28]};
            3'd2: readdata = hex_all;
            3'd3: readdata = {8'h00, blink_mask, enable_reg, 6'd0, blink_en, mode_reg};
            3'd4: readdata = {8'h00, blink_div};
            3'd5: readdata = {31'd0, phase};
            default: readdata = 32'd0;
        endcase
    end

endmodule

// File: doc/seg7_display_ctrl.md
SEG7_DISPLAY_CTRL -- requirements
Module: seg7_display_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8, number of 7-segment digits driven, legal range 1..8.
REQ-002 SHALL have parameter BLINK_DIV_RST, default 24'd12_500_000, reset value of the BLINK_DIV register.
REQ-003 SHALL have port clk, input, 1, clock.
REQ-004 SHALL have port reset_n, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port address, input, 3, Avalon-MM word address.
REQ-006 SHALL have port chipselect, input, 1, slave select.
REQ-007 SHALL have port write_n, input, 1, active-low write strobe.
REQ-008 SHALL have port writedata, input, 32, write data.
REQ-009 SHALL have port readdata, output, 32, read data, combinational from address with zero wait states.
REQ-010 SHALL have port seg_out, output, 7*NUM_DIGITS, active-low segments; digit d occupies bits [7d+6:7d], with g in bit 6 and a in bit 0.

Function
REQ-011 SHALL use this register map (write = chipselect & ~write_n): 0 RAW_LO (byte d[6:0] = raw segments for digit d, d = 0..3); 1 RAW_HI (digits 4..7); 2 HEX (nibble d = hex value for digit d); 3 CTRL; 4 BLINK_DIV[23:0]; 5 STATUS (read-only).
REQ-012 SHALL lay out CTRL as: bit0 MODE (0 = raw, 1 = hex); bit1 BLINK_EN; [15:8] ENABLE mask; [23:16] BLINK_MASK. All other bits read 0.
REQ-013 SHALL ignore writes and return 0 on reads for addresses 6..7, for STATUS writes, for register bits belonging to digits >= NUM_DIGITS, and for byte bit 7 of RAW_LO/RAW_HI.
REQ-014 SHALL compute per-digit pattern P as: raw byte when MODE = 0; hex decode of the nibble when MODE = 1.
REQ-015 Hex decode table (0..F) SHALL be: 40, 79, 24, 30, 19, 12, 02, 78, 00, 10, 08, 03, 46, 21, 06, 0E (hex).
REQ-016 SHALL override P with 7'h7F (blank) when the digit's ENABLE bit is 0, or when BLINK_EN = 1, the digit's BLINK_MASK bit is 1 and phase = 1.
REQ-017 SHALL register seg_out: a register write at clock edge N is reflected on seg_out at edge N+1.
REQ-018 Blink counter SHALL count 0..BLINK_DIV; at BLINK_DIV it SHALL return to 0 and toggle phase. BLINK_DIV = 0 toggles phase every cycle.
REQ-019 A write to BLINK_DIV SHALL clear the counter in the same edge; a new value below the current count takes effect without overshoot.
REQ-020 When BLINK_EN = 0, the counter and phase SHALL be held at 0; setting BLINK_EN starts counting from 0 with phase 0 (digits visible).
REQ-021 STATUS bit0 SHALL read the current phase; bits [31:1] SHALL read 0.
REQ-022 A simultaneous counter wrap and CTRL write SHALL apply both: phase toggles, and the new CTRL is used from the next edge.

Reset
REQ-023 On reset_n low, asynchronously: each RAW byte = 8'h40; HEX = 0; MODE = 0; BLINK_EN = 0; ENABLE = all ones for existing digits; BLINK_MASK = 0; BLINK_DIV = BLINK_DIV_RST; counter = 0; phase = 0; seg_out = 7'h40 per digit (shows "0").
REQ-024 Reset deasserted mid-count or mid-blink SHALL restart the block in the REQ-023 state, with no residual phase.

Configuration
REQ-025 Macro SEG7_BLINK_EN defined: blink counter, phase, BLINK_EN, BLINK_MASK and BLINK_DIV are implemented as specified.
REQ-026 Macro SEG7_BLINK_EN undefined: no counter or phase logic; CTRL[1] and [23:16], BLINK_DIV and STATUS read 0 with writes ignored; REQ-016 reduces to the ENABLE override only.

Verification
REQ-027 Release reset, no writes -> seg_out = 7'h40 in every digit; readdata@0 = 32'h40404040; readdata@3 = 32'h0000FF00 (NUM_DIGITS = 8).
REQ-028 Write HEX = 32'hFEDCBA98, then CTRL = 32'h0000FF01 -> one cycle later, digit0..7 = 00, 10, 08, 03, 46, 21, 06, 0E.
REQ-029 Write CTRL ENABLE = 8'hF0, MODE = 0 -> digits 0..3 = 7F; digits 4..7 = RAW_HI bytes.
REQ-030 Write BLINK_DIV = 3, then CTRL = 32'h00FFFF03 -> STATUS bit0 toggles every 4 cycles; while phase = 1 all digits = 7F; clearing BLINK_EN -> phase 0 next edge.
REQ-031 Assert reset_n during blink phase 1 -> seg_out = 7'h40 per digit asynchronously; STATUS reads 0 after release.
REQ-032 Build without SEG7_BLINK_EN; write BLINK_DIV = 5 -> readdata@4 = 0; CTRL blink bits read 0.
